// File: rtl/apb_slave_mem.sv
// ---------------------------------------------------------------------------
// apb_slave_mem
//
// APB3 slave memory model with programmable wait states and an error
// response for out-of-range or misaligned addresses.
//
// Parameters:
//   ADDR_WIDTH  width of paddr
//   DATA_WIDTH  width of pwdata/prdata (8, 16 or 32)
//   DEPTH       number of DATA_WIDTH words (power of 2, >= 2)
//   BASE_ADDR   byte address of word 0 (aligned to the memory size)
//   MAX_WAIT    upper clamp on the number of inserted wait states
//
// Ports:
//   clk       APB clock, all state changes on its rising edge
//   presetn   asynchronous active-low reset
//   psel      slave select
//   penable   access-phase strobe
//   pwrite    1 = write, 0 = read
//   paddr     byte address
//   pwdata    write data
//   wait_cfg  wait states for the next transfer, sampled in the setup cycle
//   prdata    read data, nonzero only on a good read while pready is high
//   pready    transfer completes on an edge with psel & penable & pready
//   pslverr   error response, qualified by pready
//   busy      high while the FSM is in the ACCESS state
// ---------------------------------------------------------------------------
module apb_slave_mem #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  presetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [3:0]            wait_cfg,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  busy
);

    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int OFF_BITS = $clog2(BYTES);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int EXT_W    = ADDR_WIDTH + 1;

    // The counter is only 4 bits wide, so the clamp saturates at 15.
    localparam logic [3:0]            WAIT_CLAMP = (MAX_WAIT >= 15) ? 4'd15 : 4'(MAX_WAIT);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [EXT_W-1:0]      DEPTH_EXT  = EXT_W'(DEPTH);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_count;
    logic [IDX_W-1:0]        r_index;
    logic                    r_write;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic [EXT_W-1:0]        w_offset;
    logic [EXT_W-1:0]        w_index;
    logic                    w_below;
    logic                    w_range;
    logic                    w_misaligned;
    logic                    w_addrErr;
    logic [3:0]              w_waitLoad;

    // Address decode is done one bit wider than the bus so that addresses
    // near the top of the space, or below the base, cannot wrap into range.
    assign w_offset     = {1'b0, paddr} - {1'b0, BASE_ADDR};
    assign w_index      = w_offset >> OFF_BITS;
    assign w_below      = paddr < BASE_ADDR;
    assign w_range      = w_index >= DEPTH_EXT;
    assign w_misaligned = (paddr & ALIGN_MASK) != '0;
    assign w_addrErr    = w_below | w_range | w_misaligned;

    assign w_waitLoad   = (wait_cfg > WAIT_CLAMP) ? WAIT_CLAMP : wait_cfg;

    // Two-state transfer FSM. Everything the access phase needs is captured
    // in the setup cycle, so bus changes during wait states are harmless.
    // A master abort (psel low in ACCESS) drops the transfer without a write.
    always_ff @(posedge clk or negedge presetn) begin
        if (!presetn) begin
            r_state <= IDLE;
            r_count <= '0;
            r_index <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_wdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    // psel with penable but no preceding setup is ignored.
                    if (psel && !penable) begin
                        r_index <= w_index[IDX_W-1:0];
                        r_write <= pwrite;
                        r_err   <= w_addrErr;
                        r_wdata <= pwdata;
                        r_count <= w_waitLoad;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        r_state <= IDLE;
                    end else if (penable && (r_count == '0)) begin
                        if (r_write && !r_err) begin
                            r_mem[r_index] <= r_wdata;
                        end
                        r_state <= IDLE;
                    end else if (r_count != '0) begin
                        r_count <= r_count - 4'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Responses are decoded straight from the registered state, so they
    // drop to zero the moment reset is asserted.
    assign busy    = (r_state == ACCESS);
    assign pready  = busy && (r_count == '0);
    assign pslverr = pready && r_err;
    assign prdata  = (pready && !r_write && !r_err) ? r_mem[r_index] : '0;

endmodule

// File: tb/tb_apb_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_mem
//
// Self-checking bench for apb_slave_mem. A default 32-bit instance is
// exercised with directed scenarios and randomized transfers compared
// against a word-array model; a second 16-bit instance with a nonzero base
// address covers the parametric decode.
// ---------------------------------------------------------------------------
module tb_apb_slave_mem;

    logic        clk = 1'b0;
    logic        presetn;
    int          cycleCount = 0;
    int          checks = 0;
    int          failures = 0;

    // 32-bit instance signals
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  wait_cfg;
    logic        pready, pslverr, busy;

    // 16-bit instance signals
    logic        p16Sel, p16Enable, p16Write;
    logic [31:0] p16Addr;
    logic [15:0] p16Wdata, p16Rdata;
    logic [3:0]  p16Wait;
    logic        p16Ready, p16Err, p16Busy;

    // Reference memories, indexed by word
    logic [31:0] modelMem [16];
    logic [15:0] modelMem16 [8];

    apb_slave_mem dut (
        .clk      (clk),
        .presetn  (presetn),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .wait_cfg (wait_cfg),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .busy     (busy)
    );

    apb_slave_mem #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (16),
        .DEPTH      (8),
        .BASE_ADDR  (32'h100),
        .MAX_WAIT   (15)
    ) dut16 (
        .clk      (clk),
        .presetn  (presetn),
        .psel     (p16Sel),
        .penable  (p16Enable),
        .pwrite   (p16Write),
        .paddr    (p16Addr),
        .pwdata   (p16Wdata),
        .wait_cfg (p16Wait),
        .prdata   (p16Rdata),
        .pready   (p16Ready),
        .pslverr  (p16Err),
        .busy     (p16Busy)
    );

    // 100 ns clock period
    always #50 clk = ~clk;

    // Free-running edge counter used to measure transfer length
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Hard stop in case some wait escapes its bound
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Address error rule in plain arithmetic: below base, beyond the last
    // word, or not on a word boundary.
    function automatic bit modelAddrErr(input longint unsigned a, input longint unsigned base,
                                        input longint unsigned bytes, input longint unsigned depth);
        if (a < base) return 1'b1;
        if ((a % bytes) != 0) return 1'b1;
        return ((a - base) / bytes) >= depth;
    endfunction

    // One complete APB transfer on the 32-bit instance. The setup is driven
    // on a falling edge; during wait states paddr/pwdata/wait_cfg are
    // scrambled to show they are not re-sampled. Returns the response seen
    // while pready was high, plus wait, busy and edge counts.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] wcfg, output logic [31:0] rdata, output logic err,
                                 output int waits, output int busyCnt, output int cycles);
        int start;
        bit done;
        @(negedge clk);
        start   = cycleCount;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        wait_cfg = wcfg;
        @(negedge clk);
        penable  = 1'b1;
        wait_cfg = 4'($urandom);
        waits   = 0;
        busyCnt = 0;
        rdata   = '0;
        err     = 1'b0;
        cycles  = 0;
        done    = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (busy) busyCnt++;
            if (pready) begin
                done = 1'b1;
            end else begin
                waits++;
                pwdata = $urandom;
                paddr  = $urandom;
                @(negedge clk);
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL pready_timeout addr=%h got=no_pready exp=pready", addr);
            psel    = 1'b0;
            penable = 1'b0;
        end else begin
            rdata = prdata;
            err   = pslverr;
            @(posedge clk);
            #1;
            psel    = 1'b0;
            penable = 1'b0;
            cycles  = cycleCount - start;
        end
    endtask

    // Zero-wait transfer on the 16-bit instance.
    task automatic applyStimulus16(input logic wr, input logic [31:0] addr, input logic [15:0] data,
                                   output logic [15:0] rdata, output logic err);
        bit done;
        @(negedge clk);
        p16Sel    = 1'b1;
        p16Enable = 1'b0;
        p16Write  = wr;
        p16Addr   = addr;
        p16Wdata  = data;
        p16Wait   = 4'd0;
        @(negedge clk);
        p16Enable = 1'b1;
        rdata = '0;
        err   = 1'b0;
        done  = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            if (p16Ready) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL p16_timeout addr=%h got=no_pready exp=pready", addr);
        end else begin
            rdata = p16Rdata;
            err   = p16Err;
            @(posedge clk);
            #1;
        end
        p16Sel    = 1'b0;
        p16Enable = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        logic        er;
        int          w, b, c;
        presetn = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; wait_cfg = '0;
        p16Sel = 1'b0; p16Enable = 1'b0; p16Write = 1'b0; p16Addr = '0; p16Wdata = '0; p16Wait = '0;
        for (int i = 0; i < 16; i++) modelMem[i] = '0;
        for (int i = 0; i < 8; i++) modelMem16[i] = '0;
        #250;
        checks++;
        if (prdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_prdata got=%h exp=0", prdata); end
        checks++;
        if (pready !== 1'b0) begin failures++; $display("[TB] FAIL reset_pready got=%b exp=0", pready); end
        checks++;
        if (pslverr !== 1'b0) begin failures++; $display("[TB] FAIL reset_pslverr got=%b exp=0", pslverr); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (p16Busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy16 got=%b exp=0", p16Busy); end
        #250;
        @(negedge clk);
        presetn = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 4'd0, rd, er, w, b, c);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("[TB] FAIL reset_read0 got=%h exp=0", rd); end
        checks++;
        if (er !== 1'b0) begin failures++; $display("[TB] FAIL reset_read0_err got=%b exp=0", er); end
    endtask

    // penable with psel but no setup cycle must be ignored.
    task automatic test_protocol_violation;
        @(negedge clk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h11111111;
        wait_cfg = 4'd0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (pready !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL protocol_violation got=pready%b_busy%b exp=pready0_busy0", pready, busy);
            end
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_zero_wait;
        logic [31:0] rd;
        logic        er;
        int          w, b, c;
        applyStimulus(1'b1, 32'h4, 32'hDEADBEEF, 4'd0, rd, er, w, b, c);
        modelMem[1] = 32'hDEADBEEF;
        checks++;
        if (w !== 0 || c !== 2) begin failures++; $display("[TB] FAIL zw_write_timing got=w%0d_c%0d exp=w0_c2", w, c); end
        checks++;
        if (er !== 1'b0) begin failures++; $display("[TB] FAIL zw_write_err got=%b exp=0", er); end
        // Read issued in the very next cycle sees the freshly written word.
        applyStimulus(1'b0, 32'h4, 32'h0, 4'd0, rd, er, w, b, c);
        checks++;
        if (rd !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL zw_read got=%h exp=deadbeef", rd); end
        checks++;
        if (w !== 0 || c !== 2) begin failures++; $display("[TB] FAIL zw_read_timing got=w%0d_c%0d exp=w0_c2", w, c); end
    endtask

    task automatic test_wait_states;
        logic [31:0] rd;
        logic        er;
        int          w, b, c;
        applyStimulus(1'b1, 32'h8, 32'h12345678, 4'd3, rd, er, w, b, c);
        modelMem[2] = 32'h12345678;
        checks++;
        if (w !== 3) begin failures++; $display("[TB] FAIL ws_waits got=%0d exp=3", w); end
        checks++;
        if (b !== 4) begin failures++; $display("[TB] FAIL ws_busy_cycles got=%0d exp=4", b); end
        checks++;
        if (c !== 5) begin failures++; $display("[TB] FAIL ws_edges got=%0d exp=5", c); end
        applyStimulus(1'b0, 32'h8, 32'h0, 4'd0, rd, er, w, b, c);
        checks++;
        if (rd !== 32'h12345678) begin failures++; $display("[TB] FAIL ws_read got=%h exp=12345678", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd;
        logic        er;
        int          w, b, c;
        applyStimulus(1'b1, 32'h40, 32'hFFFFFFFF, 4'd2, rd, er, w, b, c);
        checks++;
        if (er !== 1'b1) begin failures++; $display("[TB] FAIL err_write_range got=%b exp=1", er); end
        checks++;
        if (w !== 2) begin failures++; $display("[TB] FAIL err_write_waits got=%0d exp=2", w); end
        // No word anywhere may have picked up the rejected data.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 32'(i * 4), 32'h0, 4'd0, rd, er, w, b, c);
            checks++;
            if (rd !== modelMem[i]) begin
                failures++;
                $display("[TB] FAIL err_scan_word%0d got=%h exp=%h", i, rd, modelMem[i]);
            end
        end
        applyStimulus(1'b0, 32'h2, 32'h0, 4'd0, rd, er, w, b, c);
        checks++;
        if (er !== 1'b1) begin failures++; $display("[TB] FAIL err_misaligned got=%b exp=1", er); end
        checks++;
        if (rd !== 32'h0) begin failures++; $display("[TB] FAIL err_misaligned_data got=%h exp=0", rd); end
    endtask

    task automatic test_abort;
        logic [31:0] rd;
        logic        er;
        int          w, b, c;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'hCAFEF00D; wait_cfg = 4'd5;
        @(negedge clk);
        penable = 1'b1;
        checks++;
        if (busy !== 1'b1 || pready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_access got=busy%b_pready%b exp=busy1_pready0", busy, pready);
        end
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || pready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_idle got=busy%b_pready%b exp=busy0_pready0", busy, pready);
        end
        applyStimulus(1'b0, 32'hC, 32'h0, 4'd0, rd, er, w, b, c);
        checks++;
        if (rd !== modelMem[3] || c !== 2) begin
            failures++;
            $display("[TB] FAIL abort_no_write got=%h_c%0d exp=%h_c2", rd, c, modelMem[3]);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        logic        er;
        int          w, b, c;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h5555AAAA; wait_cfg = 4'd4;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        presetn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || pready !== 1'b0 || pslverr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_outputs got=busy%b_pready%b_err%b exp=000", busy, pready, pslverr);
        end
        for (int i = 0; i < 16; i++) modelMem[i] = '0;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        presetn = 1'b1;
        applyStimulus(1'b0, 32'h10, 32'h0, 4'd0, rd, er, w, b, c);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("[TB] FAIL reset_mid_target got=%h exp=0", rd); end
        applyStimulus(1'b0, 32'h4, 32'h0, 4'd0, rd, er, w, b, c);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("[TB] FAIL reset_mid_cleared got=%h exp=0", rd); end
    endtask

    // Randomized back-to-back transfers, mixing good, out-of-range,
    // misaligned and top-of-space addresses.
    task automatic test_random;
        logic [31:0] rd, addr, data, expRd;
        logic        er, wr, expErr;
        logic [3:0]  wcfg;
        int          w, b, c, sel, idx;
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       addr = $urandom_range(0, 15) * 4;
            else if (sel == 6) addr = $urandom_range(16, 63) * 4;
            else if (sel < 9)  addr = $urandom_range(0, 63);
            else               addr = 32'hFFFFFFF0 | $urandom_range(0, 15);
            wr   = 1'($urandom_range(0, 1));
            data = $urandom;
            wcfg = 4'($urandom_range(0, 3));
            expErr = modelAddrErr(addr, 0, 4, 16);
            idx    = expErr ? 0 : int'(addr / 4);
            expRd  = (!wr && !expErr) ? modelMem[idx] : 32'h0;
            applyStimulus(wr, addr, data, wcfg, rd, er, w, b, c);
            checks++;
            if (er !== expErr) begin
                failures++;
                $display("[TB] FAIL rand%0d_err addr=%h got=%b exp=%b", n, addr, er, expErr);
            end
            checks++;
            if (rd !== expRd) begin
                failures++;
                $display("[TB] FAIL rand%0d_rdata addr=%h got=%h exp=%h", n, addr, rd, expRd);
            end
            checks++;
            if (w !== int'(wcfg) || c !== int'(wcfg) + 2 || b !== int'(wcfg) + 1) begin
                failures++;
                $display("[TB] FAIL rand%0d_timing got=w%0d_c%0d_b%0d exp=w%0d", n, w, c, b, wcfg);
            end
            if (wr && !expErr) modelMem[idx] = data;
        end
    endtask

    task automatic test_param16;
        logic [15:0] rd;
        logic        er;
        logic [31:0] addrs [5];
        addrs[0] = 32'h110; addrs[1] = 32'hFE; addrs[2] = 32'h101; addrs[3] = 32'h10E; addrs[4] = 32'h100;
        applyStimulus16(1'b1, 32'h10E, 16'hA5A5, rd, er);
        if (!modelAddrErr(32'h10E, 32'h100, 2, 8)) modelMem16[7] = 16'hA5A5;
        applyStimulus16(1'b1, 32'h100, 16'h1234, rd, er);
        if (!modelAddrErr(32'h100, 32'h100, 2, 8)) modelMem16[0] = 16'h1234;
        // An out-of-range write that would alias word 0 if the decode wrapped.
        applyStimulus16(1'b1, 32'h110, 16'hFFFF, rd, er);
        checks++;
        if (er !== 1'b1) begin failures++; $display("[TB] FAIL p16_write_range got=%b exp=1", er); end
        for (int i = 0; i < 5; i++) begin
            applyStimulus16(1'b0, addrs[i], 16'h0, rd, er);
            checks++;
            if (er !== modelAddrErr(addrs[i], 32'h100, 2, 8)) begin
                failures++;
                $display("[TB] FAIL p16_err_%h got=%b exp=%b", addrs[i], er, ~er);
            end
            checks++;
            if (rd !== (er ? 16'h0 : modelMem16[(addrs[i] - 32'h100) / 2])) begin
                failures++;
                $display("[TB] FAIL p16_rdata_%h got=%h", addrs[i], rd);
            end
        end
    endtask

    // Scenario sequence and final summary
    initial begin
        test_reset();
        test_protocol_violation();
        test_zero_wait();
        test_wait_states();
        test_errors();
        test_abort();
        test_reset_mid();
        test_random();
        test_param16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
